reg_file_wr_arbiter: RTL and testbench

//  Shares the single register-file write port among NumReq writeback requesters using round-robin arbitration.

---
 rtl/reg_file_wr_arbiter.sv | 171 +++++++++++++++++
 tb/tb_reg_file_wr_arbiter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_wr_arbiter.sv
// -----------------------------------------------------------------------------
// reg_file_wr_arbiter
//
// Shares the single register-file write port among NumReq writeback
// requesters using round-robin arbitration. The accepted write is registered
// onto the rf_write_* outputs one cycle after the handshake. A clear sequencer
// sweeps zeros into every register on request, giving a soft re-init without
// asserting rst.
//
// Ports:
//   clk            clock, rising edge
//   rst            asynchronous reset, active-high
//   req_valid      per-requester write request
//   req_addr       packed addresses, requester i at [i*IndexWidth +: IndexWidth]
//   req_data       packed data, requester i at [i*DataWidth +: DataWidth]
//   req_ready      one-hot grant (combinational)
//   clear_req      start zero-sweep of all registers
//   clear_busy     high while the sweep is in progress
//   clear_done     one-cycle pulse alongside the final sweep write
//   rf_write_en    register file writeEn (registered)
//   rf_write_addr  register file writeAddr (registered)
//   rf_write_data  register file writeData (registered)
//   grant_id       requester owning the current rf write (registered)
//
// Build option:
//   ZERO_REG_PROTECT_EN  when defined, requests to address 0 still handshake
//                        and advance the round-robin pointer, but the write is
//                        discarded (rf_write_en stays 0). The clear sweep still
//                        writes register 0.
// -----------------------------------------------------------------------------
module reg_file_wr_arbiter #(
   parameter int DataWidth  = 64,
   parameter int NumRegs    = 32,
   parameter int IndexWidth = $clog2(NumRegs),
   parameter int NumReq     = 3,
   parameter int GntWidth   = (NumReq > 1) ? $clog2(NumReq) : 1
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [NumReq-1:0]              req_valid,
   input  logic [NumReq*IndexWidth-1:0]   req_addr,
   input  logic [NumReq*DataWidth-1:0]    req_data,
   output logic [NumReq-1:0]              req_ready,
   input  logic                           clear_req,
   output logic                           clear_busy,
   output logic                           clear_done,
   output logic                           rf_write_en,
   output logic [IndexWidth-1:0]          rf_write_addr,
   output logic [DataWidth-1:0]           rf_write_data,
   output logic [GntWidth-1:0]            grant_id
);

   typedef enum logic {IDLE, CLEAR} state_t;

   localparam logic [IndexWidth-1:0] LastIdx = IndexWidth'(NumRegs - 1);

   state_t                  state_q, state_d;
   logic [GntWidth-1:0]     rr_ptr, rr_ptr_d;
   logic [IndexWidth-1:0]   clr_idx, clr_idx_d;

   logic                    gnt_found;
   logic [GntWidth-1:0]     gnt_idx;
   logic [GntWidth-1:0]     cand;
   int                      cand_sum;

   logic                    wr_en_d;
   logic [IndexWidth-1:0]   wr_addr_d;
   logic [DataWidth-1:0]    wr_data_d;
   logic [GntWidth-1:0]     grant_d;
   logic                    done_d;
   logic [IndexWidth-1:0]   sel_addr;
   logic [DataWidth-1:0]    sel_data;

   // Round-robin scan starting at rr_ptr; only active in IDLE with no clear
   // pending, so a simultaneous clear_req suppresses every ready bit.
   always_comb begin
      gnt_found = 1'b0;
      gnt_idx   = '0;
      cand      = '0;
      cand_sum  = 0;
      req_ready = '0;
      if (state_q == IDLE && !clear_req) begin
         for (int off = 0; off < NumReq; off++) begin
            cand_sum = int'(rr_ptr) + off;
            if (cand_sum >= NumReq) cand_sum = cand_sum - NumReq;
            cand = GntWidth'(cand_sum);
            if (!gnt_found && req_valid[cand]) begin
               gnt_found = 1'b1;
               gnt_idx   = cand;
            end
         end
         if (gnt_found) req_ready[gnt_idx] = 1'b1;
      end
   end

   assign sel_addr = req_addr[int'(gnt_idx)*IndexWidth +: IndexWidth];
   assign sel_data = req_data[int'(gnt_idx)*DataWidth +: DataWidth];

   // Next-state and next-output logic; addr/data hold unless a write is issued.
   always_comb begin
      state_d    = state_q;
      rr_ptr_d   = rr_ptr;
      clr_idx_d  = clr_idx;
      wr_en_d    = 1'b0;
      wr_addr_d  = rf_write_addr;
      wr_data_d  = rf_write_data;
      grant_d    = grant_id;
      done_d     = 1'b0;
      clear_busy = (state_q == CLEAR);
      case (state_q)
         IDLE: begin
            if (clear_req) begin
               state_d   = CLEAR;
               clr_idx_d = '0;
            end else if (gnt_found) begin
`ifdef ZERO_REG_PROTECT_EN
               // Write to register 0 is swallowed; addr/data still load but
               // are harmless with the enable low.
               wr_en_d = (sel_addr != '0);
`else
               wr_en_d = 1'b1;
`endif
               wr_addr_d = sel_addr;
               wr_data_d = sel_data;
               grant_d   = gnt_idx;
               if (int'(gnt_idx) == NumReq - 1) rr_ptr_d = '0;
               else                             rr_ptr_d = gnt_idx + 1'b1;
            end
         end
         CLEAR: begin
            wr_en_d   = 1'b1;
            wr_addr_d = clr_idx;
            wr_data_d = '0;
            grant_d   = '0;
            // Terminal compare against NumRegs-1 so non-power-of-two sizes stop
            // at the last real register.
            if (clr_idx == LastIdx) begin
               state_d   = IDLE;
               clr_idx_d = '0;
               done_d    = 1'b1;
            end else begin
               clr_idx_d = clr_idx + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= IDLE;
         rr_ptr        <= '0;
         clr_idx       <= '0;
         rf_write_en   <= 1'b0;
         rf_write_addr <= '0;
         rf_write_data <= '0;
         grant_id      <= '0;
         clear_done    <= 1'b0;
      end else begin
         state_q       <= state_d;
         rr_ptr        <= rr_ptr_d;
         clr_idx       <= clr_idx_d;
         rf_write_en   <= wr_en_d;
         rf_write_addr <= wr_addr_d;
         rf_write_data <= wr_data_d;
         grant_id      <= grant_d;
         clear_done    <= done_d;
      end
   end

endmodule

// File: tb/tb_reg_file_wr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_reg_file_wr_arbiter
//
// Directed testbench for reg_file_wr_arbiter with NumReq=3, NumRegs=32,
// DataWidth=64. Inputs change 1 time unit after the rising edge; outputs are
// observed 1-2 time units after the edge.
// -----------------------------------------------------------------------------
module tb_reg_file_wr_arbiter;

   localparam int DataWidth  = 64;
   localparam int NumRegs    = 32;
   localparam int IndexWidth = 5;
   localparam int NumReq     = 3;
   localparam int GntWidth   = 2;

   logic                         clk = 1'b0;
   logic                         rst = 1'b1;
   logic [NumReq-1:0]            req_valid = '0;
   logic [NumReq*IndexWidth-1:0] req_addr  = '0;
   logic [NumReq*DataWidth-1:0]  req_data  = '0;
   logic [NumReq-1:0]            req_ready;
   logic                         clear_req = 1'b0;
   logic                         clear_busy;
   logic                         clear_done;
   logic                         rf_write_en;
   logic [IndexWidth-1:0]        rf_write_addr;
   logic [DataWidth-1:0]         rf_write_data;
   logic [GntWidth-1:0]          grant_id;

   int n_checks = 0;
   int n_errors = 0;

   reg_file_wr_arbiter #(
      .DataWidth (DataWidth),
      .NumRegs   (NumRegs),
      .NumReq    (NumReq)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .req_valid     (req_valid),
      .req_addr      (req_addr),
      .req_data      (req_data),
      .req_ready     (req_ready),
      .clear_req     (clear_req),
      .clear_busy    (clear_busy),
      .clear_done    (clear_done),
      .rf_write_en   (rf_write_en),
      .rf_write_addr (rf_write_addr),
      .rf_write_data (rf_write_data),
      .grant_id      (grant_id)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input logic [IndexWidth-1:0] a, input logic [DataWidth-1:0] d);
      req_addr[i*IndexWidth +: IndexWidth] = a;
      req_data[i*DataWidth +: DataWidth]   = d;
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, " en"},    64'(rf_write_en),   64'd0);
      check({tag, " addr"},  64'(rf_write_addr), 64'd0);
      check({tag, " data"},  rf_write_data,      64'd0);
      check({tag, " gnt"},   64'(grant_id),      64'd0);
      check({tag, " busy"},  64'(clear_busy),    64'd0);
      check({tag, " done"},  64'(clear_done),    64'd0);
   endtask

   initial begin
      int exp_g[6];
      exp_g = '{1, 2, 0, 1, 2, 0};

      // ---------------- reset state ----------------
      tick();
      tick();
      check_idle_outputs("reset");
      check("reset ready", 64'(req_ready), 64'd0);
      rst = 1'b0;
      tick();

      // ---------------- test 1: single request ----------------
      set_req(0, 5'd5, 64'hDEAD);
      req_valid = 3'b001;
      #1;
      check("t1 ready", 64'(req_ready), 64'b001);
      tick();
      check("t1 en",   64'(rf_write_en),   64'd1);
      check("t1 addr", 64'(rf_write_addr), 64'd5);
      check("t1 data", rf_write_data,      64'hDEAD);
      check("t1 gnt",  64'(grant_id),      64'd0);
      req_valid = '0;
      // rr_ptr now 1

      // ---------------- test 2: all three requesting ----------------
      for (int i = 0; i < NumReq; i++) set_req(i, 5'(10 + i), 64'(32'h100 + i));
      req_valid = 3'b111;
      for (int c = 0; c < 6; c++) begin
         #1;
         check($sformatf("t2 ready%0d", c), 64'(req_ready), 64'(3'b001 << exp_g[c]));
         tick();
         check($sformatf("t2 en%0d", c),   64'(rf_write_en),   64'd1);
         check($sformatf("t2 addr%0d", c), 64'(rf_write_addr), 64'(10 + exp_g[c]));
         check($sformatf("t2 data%0d", c), rf_write_data,      64'(32'h100 + exp_g[c]));
         check($sformatf("t2 gnt%0d", c),  64'(grant_id),      64'(exp_g[c]));
      end
      req_valid = '0;
      // rr_ptr now 1

      // ---------------- test 3: clear sweep with colliding request ----------
      set_req(1, 5'd7, 64'h77);
      req_valid = 3'b010;
      clear_req = 1'b1;
      #1;
      check("t3 ready at clear", 64'(req_ready),  64'd0);
      check("t3 busy pre",       64'(clear_busy), 64'd0);
      tick();
      clear_req = 1'b0;
      #1;
      check("t3 busy",     64'(clear_busy),  64'd1);
      check("t3 ready0",   64'(req_ready),   64'd0);
      check("t3 en first", 64'(rf_write_en), 64'd0);
      for (int j = 0; j < NumRegs; j++) begin
         tick();
         check($sformatf("t3 en%0d", j),   64'(rf_write_en),   64'd1);
         check($sformatf("t3 addr%0d", j), 64'(rf_write_addr), 64'(j));
         check($sformatf("t3 data%0d", j), rf_write_data,      64'd0);
         check($sformatf("t3 gnt%0d", j),  64'(grant_id),      64'd0);
         check($sformatf("t3 done%0d", j), 64'(clear_done),    64'(j == NumRegs - 1));
         check($sformatf("t3 busy%0d", j), 64'(clear_busy),    64'(j != NumRegs - 1));
         check($sformatf("t3 ready%0d", j), 64'(req_ready),    (j == NumRegs - 1) ? 64'b010 : 64'd0);
      end
      tick();
      check("t3 post en",   64'(rf_write_en),   64'd1);
      check("t3 post addr", 64'(rf_write_addr), 64'd7);
      check("t3 post data", rf_write_data,      64'h77);
      check("t3 post gnt",  64'(grant_id),      64'd1);
      check("t3 post done", 64'(clear_done),    64'd0);
      req_valid = '0;
      // rr_ptr now 2

      // ---------------- test 4: reset mid-sweep ----------------
      clear_req = 1'b1;
      tick();
      clear_req = 1'b0;
      for (int j = 0; j < 10; j++) tick();
      check("t4 addr before rst", 64'(rf_write_addr), 64'd9);
      check("t4 busy before rst", 64'(clear_busy),    64'd1);
      rst = 1'b1;
      #1;
      check_idle_outputs("t4 rst");
      tick();
      check("t4 done in rst", 64'(clear_done), 64'd0);
      rst = 1'b0;
      for (int j = 0; j < 3; j++) begin
         tick();
         check($sformatf("t4 done after%0d", j), 64'(clear_done), 64'd0);
         check($sformatf("t4 en after%0d", j),   64'(rf_write_en), 64'd0);
      end
      req_valid = 3'b111;
      #1;
      check("t4 ready ptr0", 64'(req_ready), 64'b001);
      tick();
      check("t4 gnt",  64'(grant_id),      64'd0);
      check("t4 addr", 64'(rf_write_addr), 64'd10);
      req_valid = '0;
      // rr_ptr now 1

      // ---------------- test 5: write to address 0 ----------------
      set_req(2, 5'd0, 64'hFF);
      req_valid = 3'b100;
      #1;
      check("t5 ready", 64'(req_ready), 64'b100);
      tick();
`ifdef ZERO_REG_PROTECT_EN
      check("t5 en",  64'(rf_write_en), 64'd0);
`else
      check("t5 en",   64'(rf_write_en),   64'd1);
      check("t5 addr", 64'(rf_write_addr), 64'd0);
      check("t5 data", rf_write_data,      64'hFF);
`endif
      check("t5 gnt", 64'(grant_id), 64'd2);
      req_valid = '0;
      // rr_ptr now 0

      // ---------------- test 6: wrap after grant to 2 ----------------
      set_req(0, 5'd12, 64'hA0);
      set_req(2, 5'd3,  64'hA2);
      req_valid = 3'b101;
      #1;
      check("t6 ready a", 64'(req_ready), 64'b001);
      tick();
      check("t6 gnt a",  64'(grant_id),      64'd0);
      check("t6 addr a", 64'(rf_write_addr), 64'd12);
      check("t6 ready b", 64'(req_ready),    64'b100);
      tick();
      check("t6 gnt b",  64'(grant_id),      64'd2);
      check("t6 data b", rf_write_data,      64'hA2);
      req_valid = '0;
      tick();
      check("t6 idle en",   64'(rf_write_en),   64'd0);
      check("t6 hold addr", 64'(rf_write_addr), 64'd3);
      check("t6 hold data", rf_write_data,      64'hA2);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
